c_multiplier_pipe: RTL and testbench
====================================

Name: c_multiplier_pipe

Overview:
- Parametrised, pipelined constant-coefficient multiplier for the FFT butterfly datapath; next generation of the fixed shift-add twiddle multiplier.
- Computes result = a * C, where C is a fractional constant set by a shift mask: C = sum of 2^-k for every set bit k.
- Adds signed arithmetic, a per-sample mode (±C, bypass, zero), valid tracking, clock-enable stall and output saturation.

Parameters:
- N, 4, data width W = 2**N bits, signed two's complement.
- COEF_MASK, 16'h015A, W-bit mask. Bit k (1..W-1) set adds term a>>>k. Bit 0 is ignored. The default gives C = 2^-1+2^-3+2^-4+2^-6+2^-8 ≈ 0.7070.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ce  input  1  clock enable; 0 = whole pipeline holds.
- in_valid  input  1  a/mode are valid this cycle.
- a  input  W  signed operand.
- mode  input  2  00 = a*C, 01 = -(a*C), 10 = a (bypass), 11 = zero.
- result  output  W  signed product, registered.
- out_valid  output  1  result is valid.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: all pipeline registers, result = 0, out_valid = 0. Reset takes priority over ce. In-flight samples are discarded, with no partial output.
- Pipeline has 3 stages, registered in order S1, S2, S3. Latency is exactly 3 ce-enabled cycles from in_valid to out_valid.
- Throughput is one sample per enabled cycle. There is no backpressure other than ce.
- ce = 0: every register, including the valid bits, holds its value.
- S1:
  - Term k is a>>>k, an arithmetic shift that floors (truncates toward -inf).
  - Lo partial = sum of enabled terms with k < W/2. Hi partial = sum of enabled terms with k >= W/2.
  - Both partials are sign-extended to W+2 bits and registered, together with a copy of a, mode and in_valid.
- S2:
  - P = lo + hi in W+2 bits.
  - Select by mode: 00 → P, 01 → -P, 10 → a sign-extended, 11 → 0.
  - Register the W+2-bit value, plus the valid bit.
- S3:
  - Saturate the W+2-bit value to W-bit signed range: > 2^(W-1)-1 → 0x7FF..F; < -2^(W-1) → 0x800..0.
  - Register the result into result and out_valid.
- Data path: register stages load every enabled cycle regardless of valid. The result of a bubble is don't-care. Benches check result only when out_valid = 1.
- Bypass negation: mode 01 never needs saturation for C < 1. Saturation is still required because the mask is a parameter and a reduced mask must not wrap.
- COEF_MASK = 0: output is 0 for mode 00/01; modes 10/11 are unaffected.
- Mode is captured with its sample. Changing mode every cycle must not affect samples already in flight.
- No combinational path from inputs to outputs.

Test Plan:
- Scaling: default mask, mode 00, a = 16'h4000 → after 3 cycles result = 16'h2D40 (11584), out_valid = 1 for one cycle.
- Negative input and negation:
  - a = 16'hC000, mode 00 → 16'hD2C0 (-11584).
  - a = 16'h4000, mode 01 → 16'hD2C0.
- Truncation boundary: a = 16'hFFFF, mode 00 → 16'hFFFB (-5, floor per term). a = 0 → 0.
- Bypass and zero:
  - a = 16'h8000, mode 10 → 16'h8000.
  - mode 11 with a = 16'h1234 → 16'h0000.
  - Back-to-back samples with alternating mode, one per cycle → outputs in order, each with its own mode.
- Stall and reset:
  - Stream 5 samples with ce low for 2 cycles mid-stream → outputs and out_valid frozen during the stall, order and values intact, total delay 3 + 2 cycles.
  - rst asserted with 2 samples in flight → next cycle out_valid = 0, result = 0; the flushed samples never appear.
- Saturation: COEF_MASK = 16'h0002 (C = 0.5), N = 4, mode 01, a = 16'h8000 → 16'h4000. Add a targeted check that a forced out-of-range S2 value saturates to 16'h7FFF / 16'h8000.

Source files
------------

// File: rtl/c_multiplier_pipe_if.sv
// Sample/result bundle for the constant-coefficient multiplier.
// The master drives operands and stall control; the slave returns the product.
interface c_multiplier_pipe_if #(
   parameter int W = 16
) ();
   logic         ce;
   logic         in_valid;
   logic [W-1:0] a;
   logic [1:0]   mode;
   logic [W-1:0] result;
   logic         out_valid;

   modport master (
      output ce, in_valid, a, mode,
      input  result, out_valid
   );

   modport slave (
      input  ce, in_valid, a, mode,
      output result, out_valid
   );
endinterface

// File: rtl/c_multiplier_pipe.sv
// Three-stage signed constant multiplier: result = a * C, C = sum of 2^-k over set COEF_MASK bits.
// Per-sample mode selects +C, -C, bypass or zero; the final stage saturates to W bits.
module c_multiplier_pipe #(
   parameter int              N         = 4,
   parameter logic [2**N-1:0] COEF_MASK = 16'h015A
) (
   input  logic                clk,
   input  logic                rst,
   c_multiplier_pipe_if.slave  bus
);
   localparam int W    = 2**N;
   localparam int WE   = W + 2;
   localparam int HALF = W / 2;

   typedef enum logic [1:0] {
      MODE_MUL  = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_BYP  = 2'b10,
      MODE_ZERO = 2'b11
   } mode_e;

   // ---------------- S1: shifted terms split into lo/hi partial sums ----------------
   logic signed [WE-1:0] term      [W];
   logic signed [WE-1:0] lo_chain  [W];
   logic signed [WE-1:0] hi_chain  [W];

   assign term[0]     = '0;
   assign lo_chain[0] = '0;
   assign hi_chain[0] = '0;

   generate
      for (genvar gi = 1; gi < W; gi++) begin : g_term
         logic signed [W-1:0] shifted;
         assign shifted = $signed(bus.a) >>> gi;
         if (COEF_MASK[gi]) begin : g_on
            assign term[gi] = {{2{shifted[W-1]}}, shifted};
         end else begin : g_off
            assign term[gi] = '0;
         end
         // Each term lands in exactly one of the two chains.
         if (gi < HALF) begin : g_lo
            assign lo_chain[gi] = lo_chain[gi-1] + term[gi];
            assign hi_chain[gi] = hi_chain[gi-1];
         end else begin : g_hi
            assign lo_chain[gi] = lo_chain[gi-1];
            assign hi_chain[gi] = hi_chain[gi-1] + term[gi];
         end
      end
   endgenerate

   logic signed [WE-1:0] lo_d, hi_d;
   logic signed [WE-1:0] lo_q, hi_q;
   logic        [W-1:0]  a_q;
   mode_e                mode_q;
   logic                 v1_q;

   assign lo_d = lo_chain[W-1];
   assign hi_d = hi_chain[W-1];

   // ---------------- S2: combine partials and apply mode ----------------
   logic signed [WE-1:0] p_sum;
   logic signed [WE-1:0] s2_d, s2_q;
   logic                 v2_q;

   assign p_sum = lo_q + hi_q;

   always_comb begin
      s2_d = '0;
      unique case (mode_q)
         MODE_MUL:  s2_d = p_sum;
         MODE_NEG:  s2_d = -p_sum;
         MODE_BYP:  s2_d = {{2{a_q[W-1]}}, a_q};
         MODE_ZERO: s2_d = '0;
         default:   s2_d = '0;
      endcase
   end

   // ---------------- S3: saturate to the W-bit signed range ----------------
   logic [W-1:0] result_d, result_q;
   logic         v3_q;
   logic [2:0]   top_bits;

   assign top_bits = s2_q[WE-1:W-1];

   always_comb begin
      result_d = s2_q[W-1:0];
      // In range only when the three top bits are all copies of the sign.
      if (top_bits != 3'b000 && top_bits != 3'b111) begin
         if (s2_q[WE-1]) begin
            result_d = {1'b1, {(W-1){1'b0}}};
         end else begin
            result_d = {1'b0, {(W-1){1'b1}}};
         end
      end
   end

   // ---------------- Pipeline registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q     <= '0;
         hi_q     <= '0;
         a_q      <= '0;
         mode_q   <= MODE_MUL;
         v1_q     <= 1'b0;
         s2_q     <= '0;
         v2_q     <= 1'b0;
         result_q <= '0;
         v3_q     <= 1'b0;
      end else if (bus.ce) begin
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         a_q      <= bus.a;
         mode_q   <= mode_e'(bus.mode);
         v1_q     <= bus.in_valid;
         s2_q     <= s2_d;
         v2_q     <= v1_q;
         result_q <= result_d;
         v3_q     <= v2_q;
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = v3_q;
endmodule

// File: tb/tb_c_multiplier_pipe.sv
// Directed bench for c_multiplier_pipe: scaling, sign, bypass/zero, stall, flush and saturation.
module tb_c_multiplier_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   c_multiplier_pipe_if #(.W(16)) bus ();
   c_multiplier_pipe_if #(.W(16)) bus_sat ();

   c_multiplier_pipe #(.N(4), .COEF_MASK(16'h015A)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   c_multiplier_pipe #(.N(4), .COEF_MASK(16'h0002)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [1:0] m);
      bus.in_valid = v;
      bus.a        = a;
      bus.mode     = m;
   endtask

   // Back-to-back stream with alternating modes.
   logic [15:0] st_a   [9] = '{16'h4000, 16'hC000, 16'h4000, 16'hFFFF, 16'h0000,
                               16'h8000, 16'h1234, 16'h4000, 16'h4000};
   logic [1:0]  st_m   [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1};
   logic [15:0] st_exp [9] = '{16'h2D40, 16'hD2C0, 16'hD2C0, 16'hFFFB, 16'h0000,
                               16'h8000, 16'h0000, 16'h4000, 16'hD2C0};

   initial begin
      bus.ce = 1'b1;
      drive(1'b0, 16'h0000, 2'd0);
      bus_sat.ce       = 1'b1;
      bus_sat.in_valid = 1'b0;
      bus_sat.a        = 16'h0000;
      bus_sat.mode     = 2'd0;

      // Reset state
      step();
      step();
      chk("reset_valid", {15'd0, bus.out_valid}, 16'h0000);
      chk("reset_result", bus.result, 16'h0000);
      rst = 1'b0;

      // Single sample: three-cycle latency, one-cycle valid pulse
      drive(1'b1, 16'h4000, 2'd0);
      step();
      drive(1'b0, 16'h0000, 2'd0);
      step();
      chk("lat_not_yet", {15'd0, bus.out_valid}, 16'h0000);
      step();
      chk("scale_valid", {15'd0, bus.out_valid}, 16'h0001);
      chk("scale_result", bus.result, 16'h2D40);
      step();
      chk("scale_pulse_end", {15'd0, bus.out_valid}, 16'h0000);

      // Back-to-back stream, each sample carrying its own mode
      for (int i = 0; i < 11; i++) begin
         if (i < 9) drive(1'b1, st_a[i], st_m[i]);
         else       drive(1'b0, 16'h0000, 2'd0);
         step();
         if (i >= 2) begin
            chk($sformatf("stream%0d_valid", i - 2), {15'd0, bus.out_valid}, 16'h0001);
            chk($sformatf("stream%0d_result", i - 2), bus.result, st_exp[i - 2]);
         end
      end
      step();
      chk("stream_drained", {15'd0, bus.out_valid}, 16'h0000);

      // Stall: five samples with ce low for two cycles mid-stream
      drive(1'b1, 16'h0011, 2'd2);
      step();
      drive(1'b1, 16'h0022, 2'd2);
      step();
      drive(1'b1, 16'h4000, 2'd0);
      step();
      chk("stall_s0_valid", {15'd0, bus.out_valid}, 16'h0001);
      chk("stall_s0", bus.result, 16'h0011);
      bus.ce = 1'b0;
      drive(1'b1, 16'h4000, 2'd1);
      step();
      chk("stall_hold1_valid", {15'd0, bus.out_valid}, 16'h0001);
      chk("stall_hold1", bus.result, 16'h0011);
      drive(1'b1, 16'h7777, 2'd3);
      step();
      chk("stall_hold2_valid", {15'd0, bus.out_valid}, 16'h0001);
      chk("stall_hold2", bus.result, 16'h0011);
      bus.ce = 1'b1;
      drive(1'b1, 16'h4000, 2'd1);
      step();
      chk("stall_s1", bus.result, 16'h0022);
      drive(1'b1, 16'h0055, 2'd2);
      step();
      chk("stall_s2", bus.result, 16'h2D40);
      drive(1'b0, 16'h0000, 2'd0);
      step();
      chk("stall_s3", bus.result, 16'hD2C0);
      step();
      chk("stall_s4_valid", {15'd0, bus.out_valid}, 16'h0001);
      chk("stall_s4", bus.result, 16'h0055);
      step();
      chk("stall_drained", {15'd0, bus.out_valid}, 16'h0000);

      // Reset with two samples in flight: they must never appear
      drive(1'b1, 16'h1111, 2'd2);
      step();
      drive(1'b1, 16'h2222, 2'd2);
      step();
      drive(1'b0, 16'h0000, 2'd0);
      rst = 1'b1;
      step();
      chk("flush_valid", {15'd0, bus.out_valid}, 16'h0000);
      chk("flush_result", bus.result, 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("flush_gone%0d", i), {15'd0, bus.out_valid}, 16'h0000);
      end

      // Reduced mask C = 0.5
      bus_sat.in_valid = 1'b1;
      bus_sat.a        = 16'h8000;
      bus_sat.mode     = 2'd1;
      step();
      bus_sat.mode     = 2'd0;
      step();
      bus_sat.in_valid = 1'b0;
      step();
      chk("half_neg_valid", {15'd0, bus_sat.out_valid}, 16'h0001);
      chk("half_neg", bus_sat.result, 16'h4000);
      step();
      chk("half_pos", bus_sat.result, 16'hC000);

      // Out-of-range values forced into the S2 register
      force dut_sat.s2_q = 18'h08000;
      step();
      chk("sat_pos_32768", bus_sat.result, 16'h7FFF);
      force dut_sat.s2_q = 18'h10000;
      step();
      chk("sat_pos_65536", bus_sat.result, 16'h7FFF);
      force dut_sat.s2_q = 18'h37FFF;
      step();
      chk("sat_neg_32769", bus_sat.result, 16'h8000);
      force dut_sat.s2_q = 18'h20000;
      step();
      chk("sat_neg_min", bus_sat.result, 16'h8000);
      force dut_sat.s2_q = 18'h07FFF;
      step();
      chk("sat_edge_max", bus_sat.result, 16'h7FFF);
      force dut_sat.s2_q = 18'h3FFFE;
      step();
      chk("sat_in_range_neg", bus_sat.result, 16'hFFFE);
      release dut_sat.s2_q;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
